// File: rtl/se_speed_change_ctl.sv
// Link-speed change sequencer for the SE receive path: quiesces framing,
// switches link_speed, then settles before re-enabling the link.
//
// state    | meaning
// IDLE     | ready for a request, link active
// WAIT_EOF | request pending, waiting for the in-flight frame to end
// QUIESCE  | one cycle, link being taken inactive
// SWITCH   | one cycle, new speed code applied
// SETTLE   | link inactive while PHY/datapath settle at the new rate
module se_speed_change_ctl #(
   parameter int SPD_W      = 2,
   parameter int INIT_SPEED = 0,
   parameter int WAIT_MAX   = 4096,
   parameter int SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sop,
   input  logic             eop,
   input  logic             valid,
   input  logic             req_valid,
   input  logic [SPD_W-1:0] req_speed,
   output logic             req_ready,
   output logic [SPD_W-1:0] link_speed,
   output logic             active,
   output logic             hold_off,
   output logic             busy,
   output logic             done,
   output logic             forced,
   output logic             hold_viol
);

   localparam int WCW = $clog2(WAIT_MAX);
   localparam int SCW = $clog2(SETTLE_CYC + 1);
   localparam logic [WCW-1:0]   WAIT_LAST   = WCW'(WAIT_MAX - 1);
   localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYC - 1);
   localparam logic [SPD_W-1:0] SPD_INIT    = SPD_W'(INIT_SPEED);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_EOF,
      S_QUIESCE,
      S_SWITCH,
      S_SETTLE
   } state_t;

   state_t           state, state_nxt;
   logic             inframe, inframe_nxt, inframe_d;
   logic [WCW-1:0]   wait_cnt, wait_nxt;
   logic [SCW-1:0]   settle_cnt, settle_nxt;
   logic [SPD_W-1:0] tgt_speed, tgt_nxt, link_nxt;
   logic             sop_v, eop_v, accept;
   logic             done_nxt, forced_nxt;

   assign sop_v       = sop & valid;
   assign eop_v       = eop & valid;
   assign inframe_nxt = (inframe | sop_v) & ~eop_v;
   assign req_ready   = (state == S_IDLE);
   assign accept      = req_valid & req_ready;

   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      settle_nxt = settle_cnt;
      tgt_nxt    = tgt_speed;
      link_nxt   = link_speed;
      inframe_d  = inframe_nxt;
      done_nxt   = 1'b0;
      forced_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               tgt_nxt = req_speed;
               if (req_speed == link_speed) begin
                  done_nxt = 1'b1;
               end else if (inframe_nxt) begin
                  state_nxt = S_WAIT_EOF;
                  wait_nxt  = '0;
               end else begin
                  state_nxt = S_QUIESCE;
               end
            end
         end
         S_WAIT_EOF: begin
            // An EOP landing in the timeout cycle still counts as a clean finish.
            if (eop_v) begin
               state_nxt = S_QUIESCE;
            end else if (wait_cnt == WAIT_LAST) begin
               forced_nxt = 1'b1;
               inframe_d  = 1'b0;
               state_nxt  = S_QUIESCE;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         S_QUIESCE: state_nxt = S_SWITCH;
         S_SWITCH: begin
            link_nxt   = tgt_speed;
            settle_nxt = '0;
            state_nxt  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               settle_nxt = settle_cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         inframe    <= 1'b0;
         wait_cnt   <= '0;
         settle_cnt <= '0;
         tgt_speed  <= SPD_INIT;
         link_speed <= SPD_INIT;
         active     <= 1'b1;
         hold_off   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         forced     <= 1'b0;
         hold_viol  <= 1'b0;
      end else begin
         state      <= state_nxt;
         inframe    <= inframe_d;
         wait_cnt   <= wait_nxt;
         settle_cnt <= settle_nxt;
         tgt_speed  <= tgt_nxt;
         link_speed <= link_nxt;
         // active drops on leaving QUIESCE and returns with the done pulse.
         active     <= !(state_nxt == S_SWITCH || state_nxt == S_SETTLE);
         hold_off   <= (state_nxt != S_IDLE);
         busy       <= (state_nxt != S_IDLE);
         done       <= done_nxt;
         forced     <= forced_nxt;
         hold_viol  <= sop_v & hold_off;
      end
   end

endmodule

// File: tb/tb_se_speed_change_ctl.sv
// Bench for se_speed_change_ctl: directed cases plus randomized requests,
// checked against a per-request timeline computed from the latency rules.
module tb_se_speed_change_ctl;
   localparam int S  = 16;
   localparam int WM = 4096;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sop, eop, valid, req_valid;
   logic [1:0] req_speed;
   logic       req_ready;
   logic [1:0] link_speed;
   logic       active, hold_off, busy, done, forced, hold_viol;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] cur_speed;

   se_speed_change_ctl #(
      .SPD_W(2), .INIT_SPEED(0), .WAIT_MAX(WM), .SETTLE_CYC(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sop(sop), .eop(eop), .valid(valid),
      .req_valid(req_valid), .req_speed(req_speed), .req_ready(req_ready),
      .link_speed(link_speed), .active(active), .hold_off(hold_off),
      .busy(busy), .done(done), .forced(forced), .hold_viol(hold_viol)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0: link idle at request; 1: mid-frame, EOP d cycles after accept
   // (d==0: never); 2: single-beat frame in the accept cycle.
   // viol_rel >= 0 places a stray single-beat frame viol_rel cycles after QUIESCE entry.
   task automatic run_req(input logic [1:0] spd, input int mode, input int d,
                          input int viol_rel, input string nm);
      bit         noop, frc;
      int         q, last;
      logic       e_hold, e_act, e_done, e_frc, e_viol;
      logic [1:0] e_spd;
      logic       hold_prev, sopv_prev;
      noop      = (spd == cur_speed);
      frc       = 1'b0;
      hold_prev = 1'b0;
      sopv_prev = 1'b0;
      if (mode == 1) begin
         @(posedge clk); #1;
         sop = 1'b1; eop = 1'b0; valid = 1'b1;
      end
      if (mode != 1)                q = 1;
      else if (d >= 1 && d <= WM)   q = 1 + d;
      else begin q = 1 + WM; frc = 1'b1; end
      last = noop ? 3 : q + S + 4;
      for (int r = 0; r <= last; r++) begin
         @(posedge clk); #1;
         sop = 1'b0; eop = 1'b0; valid = 1'b0; req_valid = 1'b0;
         if (r == 0) begin
            req_valid = 1'b1;
            req_speed = spd;
            if (mode == 2) begin sop = 1'b1; eop = 1'b1; valid = 1'b1; end
         end
         if (!noop && (r == 1 || r == 2)) begin
            req_valid = 1'b1;
            req_speed = ~spd;
         end
         if (!noop && mode == 1 && d >= 1 && r == d) begin eop = 1'b1; valid = 1'b1; end
         if (!noop && viol_rel >= 0 && r == q + viol_rel) begin
            sop = 1'b1; eop = 1'b1; valid = 1'b1;
         end
         @(negedge clk);
         if (noop) begin
            e_hold = 1'b0; e_act = 1'b1; e_spd = cur_speed;
            e_done = (r == 1); e_frc = 1'b0;
         end else begin
            e_hold = (r >= 1 && r <= q + 1 + S);
            e_act  = !(r >= q + 1 && r <= q + 1 + S);
            e_spd  = (r >= q + 2) ? spd : cur_speed;
            e_done = (r == q + 2 + S);
            e_frc  = frc && (r == q);
         end
         e_viol = sopv_prev && hold_prev;
         chk($sformatf("%s.active@%0d", nm, r),     32'(active),     32'(e_act));
         chk($sformatf("%s.hold_off@%0d", nm, r),   32'(hold_off),   32'(e_hold));
         chk($sformatf("%s.busy@%0d", nm, r),       32'(busy),       32'(e_hold));
         chk($sformatf("%s.req_ready@%0d", nm, r),  32'(req_ready),  32'(!e_hold));
         chk($sformatf("%s.link_speed@%0d", nm, r), 32'(link_speed), 32'(e_spd));
         chk($sformatf("%s.done@%0d", nm, r),       32'(done),       32'(e_done));
         chk($sformatf("%s.forced@%0d", nm, r),     32'(forced),     32'(e_frc));
         chk($sformatf("%s.hold_viol@%0d", nm, r),  32'(hold_viol),  32'(e_viol));
         sopv_prev = sop & valid;
         hold_prev = e_hold;
      end
      if (!noop) cur_speed = spd;
   endtask

   initial begin
      int         mode, d, vr;
      logic [1:0] spd;
      rst_n = 1'b1;
      sop = 1'b0; eop = 1'b0; valid = 1'b0; req_valid = 1'b0; req_speed = '0;
      cur_speed = 2'd0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst.active",     32'(active),     32'd1);
      chk("rst.link_speed", 32'(link_speed), 32'd0);
      chk("rst.hold_off",   32'(hold_off),   32'd0);
      chk("rst.busy",       32'(busy),       32'd0);
      chk("rst.req_ready",  32'(req_ready),  32'd1);
      chk("rst.done",       32'(done | forced | hold_viol), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_req(2'd2, 0, 0, -1, "idle_switch");
      run_req(2'd1, 1, 50, -1, "midframe_eop");
      run_req(2'd3, 1, 0, -1, "timeout");
      run_req(2'd3, 0, 0, -1, "noop");
      run_req(2'd0, 0, 0, 5, "viol_settle");
      run_req(2'd1, 2, 0, -1, "single_beat");

      for (int i = 0; i < 12; i++) begin
         spd  = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 2);
         if (spd == cur_speed && mode == 1) mode = 0;
         d    = $urandom_range(1, 60);
         vr   = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, S + 3);
         run_req(spd, mode, d, vr, $sformatf("rand%0d", i));
      end

      // Reset in the middle of SETTLE.
      @(posedge clk); #1;
      req_valid = 1'b1; req_speed = cur_speed + 2'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("rst_mid.active_before", 32'(active), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.active",     32'(active),     32'd1);
      chk("rst_mid.link_speed", 32'(link_speed), 32'd0);
      chk("rst_mid.busy",       32'(busy),       32'd0);
      chk("rst_mid.hold_off",   32'(hold_off),   32'd0);
      chk("rst_mid.req_ready",  32'(req_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cur_speed = 2'd0;
      run_req(2'd2, 0, 0, -1, "after_reset");

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
